// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside the ALU; owns the architectural HI/LO registers.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MTHI,
  input  logic             MTLO,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic is_signed);
    logic [WIDTH-1:0] r;
    r = v;
    if (is_signed && v[WIDTH-1]) r = ~r + 1'b1;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [W2-1:0] fix_2w(input logic [W2-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t           state;
  logic             mul_p0, neg_q_p0, neg_r_p0, dz_p0;
  logic [W2-1:0]    acc_p1, opb_p1;
  logic [WIDTH-1:0] mplr_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic             op_signed, early, last;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix, hi_res, lo_res;
  logic [WIDTH:0]   rem_sh, diff;
  logic [W2-1:0]    acc_nxt, prod;

  // Operand capture (E0): magnitudes for signed ops, sign of the results recorded
  assign op_signed = ~MDOp[0];
  assign a_mag     = mag(A, op_signed);
  assign b_mag     = mag(B, op_signed);

  // Iteration (E1..E32): multiply accumulates a left-shifting multiplicand,
  // divide keeps {remainder, quotient} in acc_p1 and shifts left each step
  assign rem_sh = acc_p1[W2-1:WIDTH-1];
  assign diff   = rem_sh - {1'b0, opb_p1[WIDTH-1:0]};

  always_comb begin
    acc_nxt = acc_p1;
    if (mul_p0) begin
      if (mplr_p1[0]) acc_nxt = acc_p1 + opb_p1;
    end else if (!diff[WIDTH]) begin
      acc_nxt = {diff[WIDTH-1:0], acc_p1[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {acc_p1[W2-2:0], 1'b0};
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early = mul_p0 && (mplr_p1[WIDTH-1:1] == '0);
`else
  assign early = 1'b0;
`endif

  assign last = (cnt_p1 == {CNT_W{1'b1}}) || early;

  // Completion: sign correction; a zero divisor leaves |A| as remainder, so HI comes out as A
  assign prod    = fix_2w(acc_nxt, neg_q_p0);
  assign quo_fix = dz_p0 ? {WIDTH{1'b1}} : fix_w(acc_nxt[WIDTH-1:0], neg_q_p0);
  assign rem_fix = fix_w(acc_nxt[W2-1:WIDTH], neg_r_p0);
  assign hi_res  = mul_p0 ? prod[W2-1:WIDTH] : rem_fix;
  assign lo_res  = mul_p0 ? prod[WIDTH-1:0]  : quo_fix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      mul_p0   <= 1'b0;
      neg_q_p0 <= 1'b0;
      neg_r_p0 <= 1'b0;
      dz_p0    <= 1'b0;
      acc_p1   <= '0;
      opb_p1   <= '0;
      mplr_p1  <= '0;
      cnt_p1   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            state    <= S_CALC;
            Busy     <= 1'b1;
            mul_p0   <= ~MDOp[1];
            neg_q_p0 <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r_p0 <= op_signed & MDOp[1] & A[WIDTH-1];
            dz_p0    <= MDOp[1] & (B == '0);
            cnt_p1   <= '0;
            if (MDOp[1]) begin
              acc_p1  <= {{WIDTH{1'b0}}, a_mag};
              opb_p1  <= {{WIDTH{1'b0}}, b_mag};
              mplr_p1 <= '0;
            end else begin
              acc_p1  <= '0;
              opb_p1  <= {{WIDTH{1'b0}}, a_mag};
              mplr_p1 <= b_mag;
            end
          end else begin
            if (MTHI) HI <= A;
            if (MTLO) LO <= A;
          end
        end
        S_CALC: begin
          acc_p1 <= acc_nxt;
          cnt_p1 <= cnt_p1 + 1'b1;
          if (mul_p0) begin
            opb_p1  <= opb_p1 << 1;
            mplr_p1 <= mplr_p1 >> 1;
          end
          if (last) begin
            HI    <= hi_res;
            LO    <= lo_res;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: products, quotients, corner divides, MT writes, abort.
module tb_mult_div_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, Start, MTHI, MTLO;
  logic [1:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int n_vec  = 0;
  int n_miss = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .MTHI(MTHI), .MTLO(MTLO), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mul_lat(input int eo);
    return EARLY ? eo : 32;
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(posedge clk);
    #1;
    Start = 1'b0; A = ~a; B = b ^ 32'h5a5a0f0f; MDOp = ~op;
  endtask

  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_n = 0;
    int done_n = 0;
    int cyc    = 0;
    while (done_n == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (Busy) busy_n++;
      if (Done) done_n++;
    end
    chk({tag, "/done"}, 64'(done_n), 64'd1);
    chk({tag, "/busy_cycles"}, 64'(busy_n), 64'(exp_lat));
    chk({tag, "/hi"}, {32'd0, HI}, {32'd0, exp_hi});
    chk({tag, "/lo"}, {32'd0, LO}, {32'd0, exp_lo});
    @(negedge clk);
    chk({tag, "/done_pulse"}, {63'd0, Done}, 64'd0);
    chk({tag, "/busy_after"}, {63'd0, Busy}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start_op(op, a, b);
    wait_done(tag, exp_lat, exp_hi, exp_lo);
  endtask

  initial begin
    int busy_n, done_n;
    reset = 1'b1; Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0; MDOp = 2'b00; A = '0; B = '0;
    @(negedge clk);
    chk("rst/busy", {63'd0, Busy}, 64'd0);
    chk("rst/done", {63'd0, Done}, 64'd0);
    chk("rst/hi", {32'd0, HI}, 64'd0);
    chk("rst/lo", {32'd0, LO}, 64'd0);
    reset = 1'b0;

    // MT writes in IDLE
    @(negedge clk); A = 32'h1234; MTLO = 1'b1;
    @(posedge clk); #1; MTLO = 1'b0;
    chk("mtlo/lo", {32'd0, LO}, 64'h1234);
    chk("mtlo/hi", {32'd0, HI}, 64'd0);
    @(negedge clk); A = 32'hCAFE0001; MTHI = 1'b1; MTLO = 1'b1;
    @(posedge clk); #1; MTHI = 1'b0; MTLO = 1'b0;
    chk("mtboth/hi", {32'd0, HI}, 64'hCAFE0001);
    chk("mtboth/lo", {32'd0, LO}, 64'hCAFE0001);

    // Start and MTHI together: Start wins
    @(negedge clk); Start = 1'b1; MTHI = 1'b1; MDOp = MULTU; A = 32'd2; B = 32'd3;
    @(posedge clk); #1; Start = 1'b0; MTHI = 1'b0; A = '0; B = '0;
    chk("st_mt/hi_hold", {32'd0, HI}, 64'hCAFE0001);
    chk("st_mt/lo_hold", {32'd0, LO}, 64'hCAFE0001);
    wait_done("st_mt", mul_lat(2), 32'h0, 32'h6);

    run_op("mult_neg",     MULT,  32'd7,        32'hFFFFFFFD, mul_lat(2), 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max",    MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32,         32'hFFFFFFFE, 32'h00000001);
    run_op("mult_m1",      MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, mul_lat(1), 32'h0,        32'h1);
    run_op("multu_zero",   MULTU, 32'h12345678, 32'h0,        mul_lat(1), 32'h0,        32'h0);
    run_op("multu_5x3",    MULTU, 32'd5,        32'd3,        mul_lat(2), 32'h0,        32'd15);
    run_op("div_neg",      DIV,   32'hFFFFFFF9, 32'd2,        32,         32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_pos_neg",  DIV,   32'd7,        32'hFFFFFFFE, 32,         32'h1,        32'hFFFFFFFD);
    run_op("div_ovf",      DIV,   32'h80000000, 32'hFFFFFFFF, 32,         32'h0,        32'h80000000);
    run_op("divu_zero",    DIVU,  32'd100,      32'h0,        32,         32'h64,       32'hFFFFFFFF);
    run_op("div_zero_neg", DIV,   32'hFFFFFFF9, 32'h0,        32,         32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("divu_big",     DIVU,  32'hFFFFFFFF, 32'd16,       32,         32'hF,        32'h0FFFFFFF);
    run_op("mult_min",     MULT,  32'h80000000, 32'd2,        mul_lat(2), 32'hFFFFFFFF, 32'h0);

    // Start / MTHI / MTLO during CALC are ignored
    start_op(DIVU, 32'd100, 32'd7);
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 100 && done_n == 0; c++) begin
      @(negedge clk);
      if (c == 5) begin
        chk("calc/hi_hold", {32'd0, HI}, 64'hFFFFFFFF);
        chk("calc/lo_hold", {32'd0, LO}, 64'h0);
        Start = 1'b1; MTHI = 1'b1; MTLO = 1'b1; A = 32'hDEADBEEF; B = 32'd2; MDOp = MULTU;
      end
      if (c == 6) begin
        Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
      end
      if (Busy) busy_n++;
      if (Done) done_n++;
    end
    chk("calc/done", 64'(done_n), 64'd1);
    chk("calc/busy_cycles", 64'(busy_n), 64'd32);
    chk("calc/hi", {32'd0, HI}, 64'd2);
    chk("calc/lo", {32'd0, LO}, 64'd14);
    repeat (4) @(negedge clk);
    chk("calc/no_restart", {63'd0, Busy}, 64'd0);
    chk("calc/hi_after", {32'd0, HI}, 64'd2);

    // Reset in the middle of a divide
    start_op(DIV, 32'hFFFFFFF9, 32'd2);
    repeat (10) @(negedge clk);
    chk("abort/busy_before", {63'd0, Busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("abort/busy", {63'd0, Busy}, 64'd0);
    chk("abort/done", {63'd0, Done}, 64'd0);
    chk("abort/hi", {32'd0, HI}, 64'd0);
    chk("abort/lo", {32'd0, LO}, 64'd0);
    @(negedge clk); reset = 1'b0;
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done || Busy) done_n++;
    end
    chk("abort/quiet", 64'(done_n), 64'd0);
    chk("abort/hi_after", {32'd0, HI}, 64'd0);
    chk("abort/lo_after", {32'd0, LO}, 64'd0);

    run_op("post_rst", MULTU, 32'd5, 32'd3, mul_lat(2), 32'h0, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
